// File: rtl/mux_src_ctrl_if.sv
// Operand-write, select-control and mux-facing output bundle for mux_src_ctrl.
// The master side drives writes/mode/switches; the slave side is the controller.
interface mux_src_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [1:0] wr_data;
  logic       mode;
  logic [1:0] sel_in;
  logic [1:0] X0;
  logic [1:0] X1;
  logic [1:0] X2;
  logic [1:0] X3;
  logic [1:0] Y;
  logic       y_step;

  modport master (
    output wr_en, wr_addr, wr_data, mode, sel_in,
    input  X0, X1, X2, X3, Y, y_step
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, mode, sel_in,
    output X0, X1, X2, X3, Y, y_step
  );
endinterface

// File: rtl/mux_src_ctrl.sv
// Operand register file and select source (debounced manual or auto-scan)
// for the downstream 4-to-1 2-bit mux; every output is registered.
module mux_src_ctrl #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned DB_CYCLES = 3
) (
  input logic           clk,
  input logic           rst,
  mux_src_ctrl_if.slave bus
);

  localparam int unsigned   CW       = $clog2(DB_CYCLES + 1);
  localparam int unsigned   DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [1:0]    r_x [4];

  logic [1:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel_stable;

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_next;
  logic [1:0]    r_y;
  logic [1:0]    w_y_next;
  logic          r_y_step;

  // Operand file: independent of mode and select logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_x[i] <= '0;
      end
    end else if (bus.wr_en) begin
      r_x[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Debouncer: a value is accepted once it has been sampled DB_CYCLES+1 times
  // in a row; the counter then saturates so the accept happens only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand       <= '0;
      r_cnt        <= '0;
      r_sel_stable <= '0;
    end else if (bus.sel_in != r_cand) begin
      r_cand <= bus.sel_in;
      r_cnt  <= '0;
    end else if (r_cnt < CNT_MAX) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CNT_LAST) begin
        r_sel_stable <= r_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_MANUAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_MANUAL: if (bus.mode)  w_state_next = ST_SCAN;
      ST_SCAN:   if (!bus.mode) w_state_next = ST_MANUAL;
      default:   w_state_next = ST_MANUAL;
    endcase
  end

  // Mode transitions hold Y for one edge; the exit also overrides a
  // coincident terminal count.
  always_comb begin
    w_y_next   = r_y;
    w_div_next = '0;
    unique case (r_state)
      ST_MANUAL: begin
        if (!bus.mode) begin
          w_y_next = r_sel_stable;
        end
      end
      ST_SCAN: begin
        if (bus.mode) begin
          if (r_div == DIV_LAST) begin
            w_y_next = r_y + 2'd1;
          end else begin
            w_div_next = r_div + DW'(1);
          end
        end
      end
      default: begin
        w_y_next   = r_y;
        w_div_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_y      <= '0;
      r_y_step <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_y      <= w_y_next;
      r_y_step <= (w_y_next != r_y);
    end
  end

  assign bus.X0     = r_x[0];
  assign bus.X1     = r_x[1];
  assign bus.X2     = r_x[2];
  assign bus.X3     = r_x[3];
  assign bus.Y      = r_y;
  assign bus.y_step = r_y_step;

endmodule

// File: tb/tb_mux_src_ctrl.sv
// Scoreboard bench for mux_src_ctrl: a run-length/edge-count reference model
// queues the expected outputs per clock edge and a monitor compares them.
module tb_mux_src_ctrl;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_src_ctrl_if bus ();

  mux_src_ctrl #(
    .SCAN_DIV  (SD),
    .DB_CYCLES (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [1:0] y;
    logic       s;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int fails  = 0;

  // Reference model state: operands, current Y, run-length of sel_in samples,
  // accepted manual select, and edges elapsed since entering scan.
  logic [1:0] mx [4];
  logic [1:0] my;
  logic       mstep;
  logic [1:0] run_val;
  int         run_len;
  logic [1:0] stable;
  bit         scanning;
  int         scan_k;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mx[i] = 2'd0;
    my       = 2'd0;
    mstep    = 1'b0;
    run_val  = 2'd0;
    run_len  = 1;
    stable   = 2'd0;
    scanning = 1'b0;
    scan_k   = 0;
  endfunction

  initial model_reset();

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    logic [1:0] ny;
    if (rst) begin
      model_reset();
    end else begin
      ny = my;
      if (!scanning) begin
        if (bus.mode) begin
          scanning = 1'b1;
          scan_k   = 0;
        end else begin
          ny = stable;
        end
      end else if (!bus.mode) begin
        scanning = 1'b0;
      end else begin
        scan_k++;
        if (scan_k % SD == 0) ny = my + 2'd1;
      end
      if (bus.sel_in == run_val) begin
        if (run_len <= DB) run_len++;
      end else begin
        run_val = bus.sel_in;
        run_len = 1;
      end
      if (run_len == DB + 1 && bus.sel_in == run_val) stable = run_val;
      if (bus.wr_en) mx[bus.wr_addr] = bus.wr_data;
      mstep = (ny != my);
      my    = ny;
    end
    q.push_back('{x: {mx[3], mx[2], mx[1], mx[0]}, y: my, s: mstep});
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = q.pop_front();
        check("X", {24'd0, bus.X3, bus.X2, bus.X1, bus.X0}, {24'd0, e.x});
        check("Y", {30'd0, bus.Y}, {30'd0, e.y});
        check("y_step", {31'd0, bus.y_step}, {31'd0, e.s});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = 2'd0;
  endtask

  initial begin
    int guard;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = 2'd0;
    bus.mode    = 1'b0;
    bus.sel_in  = 2'd0;

    // Reset held over a few edges, then four back-to-back operand writes.
    cyc(3);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = 2'((i + 1) % 4);
      cyc(1);
    end
    idle();
    cyc(2);

    // Manual select: clean change, then a glitch shorter than the accept window.
    bus.sel_in = 2'd2;
    cyc(8);
    bus.sel_in = 2'd1;
    cyc(2);
    bus.sel_in = 2'd2;
    cyc(6);

    // Scan from Y=2 through the 3->0 wrap.
    bus.mode = 1'b1;
    cyc(14);

    // Accept sel=1 while scanning, then leave scan exactly on a terminal count.
    bus.sel_in = 2'd1;
    cyc(6);
    guard = 0;
    while (!(scanning && (scan_k % SD == SD - 1)) && guard < 20) begin
      cyc(1);
      guard++;
    end
    check("exit_align_timeout", guard < 20, 1);
    bus.mode = 1'b0;
    cyc(4);

    // Writes aimed at X[Y] while scan steps land.
    bus.mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = my;
      bus.wr_data = 2'($urandom_range(0, 3));
      cyc(1);
    end
    idle();

    // Asynchronous reset between edges while Y=3.
    guard = 0;
    while (my != 2'd3 && guard < 40) begin
      cyc(1);
      guard++;
    end
    check("y3_wait_timeout", guard < 40, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_X", {24'd0, bus.X3, bus.X2, bus.X1, bus.X0}, 32'd0);
    check("async_rst_Y", {30'd0, bus.Y}, 32'd0);
    check("async_rst_y_step", {31'd0, bus.y_step}, 32'd0);
    #1 rst = 1'b0;
    cyc(6);

    // Randomised traffic: occasional select changes/glitches and mode flips.
    for (int i = 0; i < 400; i++) begin
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_addr = 2'($urandom_range(0, 3));
      bus.wr_data = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.sel_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      cyc(1);
    end
    idle();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
